// File: rtl/dl_shift_pipe.sv
// dl_shift_pipe - pipelined barrel shifter with a valid/ready handshake.
//
// Supports SLL, SRL, SRA, ROL and ROR. The $clog2(NUM_BITS) shift levels
// (level i moves by 2^i when shamt[i] is set) are grouped evenly over
// NUM_STAGES register stages. A tag rides along with each operation.
// Backpressure stalls the whole pipe; bubbles are never collapsed.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_flush      synchronous; drops every in-flight op and any same-cycle input
//   i_in_valid   input operation present
//   o_in_ready   input accepted this cycle (= !o_out_valid | i_out_ready)
//   i_in_op      000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR, others reserved
//   i_in_data    operand
//   i_in_shamt   shift amount, 0..NUM_BITS-1
//   i_in_tag     opaque tag returned with the result
//   o_out_valid  result present
//   i_out_ready  consumer takes the result
//   o_out_data   result
//   o_out_tag    tag of the result
//   o_out_err    result came from a reserved opcode (data passed unshifted)
module dl_shift_pipe #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_STAGES = 2,
  parameter int TAG_W      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [2:0]                  i_in_op,
  input  logic [NUM_BITS-1:0]         i_in_data,
  input  logic [$clog2(NUM_BITS)-1:0] i_in_shamt,
  input  logic [TAG_W-1:0]            i_in_tag,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [NUM_BITS-1:0]         o_out_data,
  output logic [TAG_W-1:0]            o_out_tag,
  output logic                        o_out_err
);

  localparam int S = $clog2(NUM_BITS);
  // Levels per stage; trailing stages may own fewer (or zero) levels.
  localparam int L = (S + NUM_STAGES - 1) / NUM_STAGES;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  // Stage registers
  logic                r_valid [NUM_STAGES];
  logic [NUM_BITS-1:0] r_data  [NUM_STAGES];
  logic [S-1:0]        r_shamt [NUM_STAGES];
  logic [2:0]          r_op    [NUM_STAGES];
  logic [TAG_W-1:0]    r_tag   [NUM_STAGES];
  logic                r_err   [NUM_STAGES];
  logic                r_fill  [NUM_STAGES];

  // Values each stage loads on an advancing edge
  logic                w_nxt_valid [NUM_STAGES];
  logic [NUM_BITS-1:0] w_nxt_data  [NUM_STAGES];
  logic [S-1:0]        w_nxt_shamt [NUM_STAGES];
  logic [2:0]          w_nxt_op    [NUM_STAGES];
  logic [TAG_W-1:0]    w_nxt_tag   [NUM_STAGES];
  logic                w_nxt_err   [NUM_STAGES];
  logic                w_nxt_fill  [NUM_STAGES];

  logic w_adv;

  // The only combinational path: out_ready -> in_ready.
  assign w_adv      = !r_valid[NUM_STAGES-1] | i_out_ready;
  assign o_in_ready = w_adv;

  function automatic logic is_reserved(input logic [2:0] op);
    return !(op == OP_SLL || op == OP_SRL || op == OP_SRA ||
             op == OP_ROL || op == OP_ROR);
  endfunction

  // One shift level by amt (a power of two, 1..NUM_BITS/2). The fill bit is
  // the operand MSB captured at acceptance, so partially shifted data never
  // decides the sign of later levels.
  function automatic logic [NUM_BITS-1:0] shift_level(
    input logic [NUM_BITS-1:0] d,
    input logic [2:0]          op,
    input logic                fill,
    input int                  amt
  );
    logic [NUM_BITS-1:0] ones;
    ones = '1;
    case (op)
      OP_SLL:         shift_level = d << amt;
      OP_SRL, OP_SRA: shift_level = (d >> amt) | (fill ? ~(ones >> amt) : '0);
      OP_ROL:         shift_level = (d << amt) | (d >> (NUM_BITS - amt));
      OP_ROR:         shift_level = (d >> amt) | (d << (NUM_BITS - amt));
      default:        shift_level = d; // reserved: effective shift of 0
    endcase
  endfunction

  always_comb begin
    logic [NUM_BITS-1:0] v_data;
    logic [S-1:0]        v_shamt;
    logic [2:0]          v_op;
    logic                v_fill;
    int                  p;
    v_data  = '0;
    v_shamt = '0;
    v_op    = '0;
    v_fill  = 1'b0;
    p       = 0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        w_nxt_valid[k] = i_in_valid;
        w_nxt_tag[k]   = i_in_tag;
        w_nxt_err[k]   = is_reserved(i_in_op);
        v_data         = i_in_data;
        v_shamt        = i_in_shamt;
        v_op           = i_in_op;
        v_fill         = (i_in_op == OP_SRA) & i_in_data[NUM_BITS-1];
      end else begin
        w_nxt_valid[k] = r_valid[p];
        w_nxt_tag[k]   = r_tag[p];
        w_nxt_err[k]   = r_err[p];
        v_data         = r_data[p];
        v_shamt        = r_shamt[p];
        v_op           = r_op[p];
        v_fill         = r_fill[p];
      end
      for (int j = 0; j < S; j++) begin
        if (j >= k * L && j < (k + 1) * L && v_shamt[j]) begin
          v_data = shift_level(v_data, v_op, v_fill, 1 << j);
        end
      end
      w_nxt_data[k]  = v_data;
      w_nxt_shamt[k] = v_shamt;
      w_nxt_op[k]    = v_op;
      w_nxt_fill[k]  = v_fill;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_op[k]    <= '0;
        r_tag[k]   <= '0;
        r_err[k]   <= 1'b0;
        r_fill[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        // flush wins over both advance and hold; it also drops the input
        // loaded into stage 0 on this edge.
        if (i_flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_adv) begin
          r_valid[k] <= w_nxt_valid[k];
        end
        if (w_adv) begin
          r_data[k]  <= w_nxt_data[k];
          r_shamt[k] <= w_nxt_shamt[k];
          r_op[k]    <= w_nxt_op[k];
          r_tag[k]   <= w_nxt_tag[k];
          r_err[k]   <= w_nxt_err[k];
          r_fill[k]  <= w_nxt_fill[k];
        end
      end
    end
  end

  assign o_out_valid = r_valid[NUM_STAGES-1];
  assign o_out_data  = r_data[NUM_STAGES-1];
  assign o_out_tag   = r_tag[NUM_STAGES-1];
  assign o_out_err   = r_err[NUM_STAGES-1];

endmodule

// File: doc/dl_shift_pipe.md
# dl_shift_pipe

Parameterised, pipelined barrel shifter with a valid/ready handshake, serving the execute-stage ALU and address-generation paths. It supports logical and arithmetic right shifts, logical left shift, and left/right rotates. The log2(NUM_BITS) shift levels are spread across NUM_STAGES register stages so the shifter can close timing at wide NUM_BITS. A sideband tag travels with each operation, and backpressure stalls the whole pipeline.

## Interface
- NUM_BITS, 32: data width; power of two, ≥ 4.
- NUM_STAGES, 2: number of register stages; range 1..$clog2(NUM_BITS).
- TAG_W, 4: width of the sideband tag carried alongside the data (≥ 1).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; clears every in-flight operation.
- in_valid  input  1  input operation present.
- in_ready  output  1  shifter accepts an input this cycle.
- in_op  input  3  opcode: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; 010/110/111 reserved.
- in_data  input  NUM_BITS  operand.
- in_shamt  input  $clog2(NUM_BITS)  shift amount.
- in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  NUM_BITS  result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  the result came from a reserved opcode.

## Operation
- Levels: the shifter has S = $clog2(NUM_BITS) levels. Level i moves the data by 2^i when shamt[i] = 1.
- Level grouping: with L = ceil(S/NUM_STAGES), stage k applies levels k·L through min((k+1)·L, S)−1. Stage k ends in a register.
- Carried state: each stage register holds valid, data, the remaining shamt bits, op, tag, err and the fill bit.
- Fill bit:
  - Captured at acceptance as in_data[NUM_BITS−1] when op = SRA, otherwise 0.
  - All later stages use this captured bit, not the partially shifted data.
- Opcode results:
  - SLL: out = in_data << shamt, zero-filled.
  - SRL: out = in_data >> shamt, zero-filled.
  - SRA: out = in_data >> shamt, filled with the original MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Reserved opcodes: data passes with an effective shift of 0 and err = 1. err = 0 for all legal opcodes.
- shamt = 0: out_data = in_data for every legal opcode.
- Shift amounts are limited to 0..NUM_BITS−1. There is no saturating shift by NUM_BITS.
- Handshake:
  - adv = !out_valid | out_ready.
  - in_ready = adv, purely combinational from out_valid and out_ready.
  - An input is accepted when in_valid & in_ready.
- Pipeline advance:
  - When adv = 1, every stage register loads from its predecessor.
  - Stage 0 loads valid = in_valid & in_ready.
  - A bubble (valid = 0) moves through like an operation.
  - When adv = 0, all stage registers hold.
  - Bubbles are not collapsed during a stall.
- Output:
  - out_* are driven directly from the last stage register.
  - While out_valid = 1 and out_ready = 0, out_data, out_tag and out_err stay stable.
- flush:
  - Clears every valid bit on the next edge, regardless of adv.
  - An input presented in the same cycle as flush is dropped, even if in_ready = 1.
  - in_ready is not gated by flush.
- Reset:
  - All valid bits clear asynchronously, so out_valid = 0.
  - out_data, out_tag and out_err reset to 0.
  - Deasserting rst_n in the middle of a stream discards all in-flight operations.
  - in_ready = 1 while in reset and immediately after it.

## Timing
- Latency: NUM_STAGES cycles from the acceptance edge to out_valid, assuming no stalls.
- Throughput: 1 operation per cycle while out_ready = 1.
- Stall: when out_ready drops, in_ready drops in the same cycle. No input is lost and no result is duplicated.
- Simultaneous output pop and input accept while the pipe is full is legal and keeps full throughput.
- Combinational path: out_ready → in_ready only. There is no path from in_* to out_*.
- NUM_STAGES = $clog2(NUM_BITS) gives one level per stage. NUM_STAGES = 1 gives a single-register shifter.

## Test plan
All scenarios use NUM_BITS = 32, NUM_STAGES = 2, TAG_W = 4.
- SRA: in_data 0x8000_00F0, shamt 4, tag 0x3 -> two cycles later out_data 0xF800_000F, out_tag 0x3, out_err 0.
- SRL / SLL / ROL / ROR on 0x8000_0001, shamt 1 -> 0x4000_0000 / 0x0000_0002 / 0x0000_0003 / 0xC000_0000.
- Streaming with backpressure:
  - Stimulus: 8 back-to-back SLLs with shamt 0..7, while out_ready follows the pattern 1,0,0,1,1,0,1,1.
  - Required: results appear in order, each exactly once.
  - Required: data is stable during stalls, and in_ready equals !out_valid | out_ready in every cycle.
- Reserved op 010 with in_data 0x1234_5678, shamt 9 -> out_data 0x1234_5678, out_err 1.
- flush with 2 operations in flight plus an input offered in the same cycle -> out_valid stays 0 for the next 3 cycles, and the next accepted operation completes normally.
- Async reset:
  - Stimulus: assert rst_n low between clock edges with the pipe full.
  - Required: out_valid drops immediately, out_data reads 0, and no stale result appears after release.
  - Repeat with NUM_STAGES = 1 and NUM_STAGES = 5 to cover latency 1 and latency 5.
